// File: rtl/muldiv_if.sv
// muldiv_if: operand/request and HI/LO result bundle between register file, control and muldiv_unit
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wen;
    logic             lo_wen;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, hi_wen, lo_wen, wdata, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, hi_wen, lo_wen, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU holding the HI/LO registers
module muldiv_unit #(parameter int WIDTH = 32) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int CW = $clog2(WIDTH);
    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div, sa, sb, done_r, sg, na_s, nb_s, ge, last;
    logic [WIDTH-1:0]   ma, mb, acc, q, hi_r, lo_r, nacc, nq, res_hi, res_lo, na, nb;
    logic [WIDTH:0]     sum, r2;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        sg     = ~bus.op[0];
        na_s   = sg & bus.a[WIDTH-1];
        nb_s   = sg & bus.b[WIDTH-1];
        na     = na_s ? -bus.a : bus.a;
        nb     = nb_s ? -bus.b : bus.b;
        sum    = {1'b0, acc} + {1'b0, {WIDTH{q[0]}} & ma};
        r2     = {acc, q[WIDTH-1]};
        ge     = r2 >= {1'b0, mb};
        nacc   = is_div ? (ge ? WIDTH'(r2 - {1'b0, mb}) : r2[WIDTH-1:0]) : sum[WIDTH:1];
        nq     = is_div ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
        prod   = (sa ^ sb) ? -{nacc, nq} : {nacc, nq};
        // remainder follows the dividend sign, so a zero divisor returns the original a in hi
        res_hi = is_div ? (sa ? -nacc : nacc) : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? ((mb == '0) ? '1 : ((sa ^ sb) ? -nq : nq)) : prod[WIDTH-1:0];
        last   = cnt == CW'(WIDTH - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            q      <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.hi_wen) hi_r <= bus.wdata;
                if (bus.lo_wen) lo_r <= bus.wdata;
                if (bus.start) begin
                    state  <= RUN;
                    cnt    <= '0;
                    is_div <= bus.op[1];
                    sa     <= na_s;
                    sb     <= nb_s;
                    ma     <= na;
                    mb     <= nb;
                    acc    <= '0;
                    q      <= bus.op[1] ? na : nb;
                end
            end else begin
                acc <= nacc;
                q   <= nq;
                cnt <= cnt + 1'b1;
                if (last) begin
                    state  <= IDLE;
                    hi_r   <= res_hi;
                    lo_r   <= res_lo;
                    done_r <= 1'b1;
                end
            end
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit arithmetic, timing, MTHI/MTLO and reset behaviour
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int n, dn;
    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
    endtask
    task automatic wait_done(output int cnt);
        int t = 0;
        cnt = 0;
        while (!bus.done && t < 100) begin
            cnt += int'(bus.busy);
            t++;
            @(negedge clk);
        end
    endtask
    task automatic watch(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            pulses += int'(bus.done);
        end
    endtask
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int c;
        go(op, a, b);
        wait_done(c);
        chk({tag, "_lat"}, c, 32);
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_hi"}, bus.hi, ehi);
        chk({tag, "_lo"}, bus.lo, elo);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(bus.done), 0);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_zero", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        // start, MTHI and MTLO pulsed mid-run must all be ignored
        go(2'b01, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.a = 32'd9;
        bus.b = 32'd3;
        bus.hi_wen = 1'b1;
        bus.lo_wen = 1'b1;
        bus.wdata = 32'hAAAA_5555;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        chk("corrupt_hold_hi", bus.hi, 32'hFFFF_FFF0);
        wait_done(n);
        chk("corrupt_lat", n, 21);
        chk("corrupt_hi", bus.hi, 0);
        chk("corrupt_lo", bus.lo, 15);
        watch(40, dn);
        chk("corrupt_extra_done", dn, 0);
        bus.lo_wen = 1'b1;
        bus.wdata = 32'h55;
        @(negedge clk);
        bus.lo_wen = 1'b0;
        chk("mtlo", bus.lo, 32'h55);
        chk("mtlo_hi_kept", bus.hi, 0);
        bus.hi_wen = 1'b1;
        bus.wdata = 32'h77;
        @(negedge clk);
        bus.hi_wen = 1'b0;
        chk("mthi", bus.hi, 32'h77);
        // reset during RUN aborts without a result
        go(2'b01, 32'hFFFF, 32'hFFFF);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        watch(40, dn);
        chk("abort_no_done", dn, 0);
        // MTHI alongside start: result overwrites hi
        bus.hi_wen = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        go(2'b01, 32'd4, 32'd5);
        bus.hi_wen = 1'b0;
        chk("mthi_start_hi", bus.hi, 32'hDEAD_BEEF);
        wait_done(n);
        chk("b2b_first_lat", n, 32);
        chk("b2b_first_lo", bus.lo, 20);
        chk("b2b_first_hi", bus.hi, 0);
        go(2'b01, 32'd2, 32'd3);
        chk("b2b_accept_busy", 32'(bus.busy), 1);
        chk("b2b_done_low", 32'(bus.done), 0);
        wait_done(n);
        chk("b2b_second_lat", n, 32);
        chk("b2b_second_lo", bus.lo, 6);
        chk("b2b_second_hi", bus.hi, 0);
        watch(5, dn);
        chk("b2b_single_done", dn, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of the register file.
- Consumes the two read ports (rdata1 → a, rdata2 → b) for MULT/MULTU/DIV/DIVU and holds the HI/LO result registers.
- The writeback mux reads hi/lo for MFHI/MFLO, and MTHI/MTLO write them directly.
- busy stalls the pipeline/control FSM while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when busy=0
- op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
- a  input  WIDTH  operand A (rdata1): multiplicand or dividend
- b  input  WIDTH  operand B (rdata2): multiplier or divisor
- hi_wen  input  1  MTHI: write wdata into hi
- lo_wen  input  1  MTLO: write wdata into lo
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when hi/lo receive a result
- hi  output  WIDTH  HI register (product high half / remainder)
- lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high: on a rising clk edge with rst=1, all state clears.
  - Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
  - rst has priority over every other input.
  - Reset during RUN aborts the operation with no hi/lo update and no done pulse.
- FSM states: IDLE, RUN.
  - IDLE→RUN on an edge with start=1.
    - On that edge: latch op, latch |a| and |b| (magnitudes for signed ops, raw values for unsigned), latch the sign bits, clear the counter and accumulator.
    - busy=1 from the next cycle.
  - RUN performs one radix-2 step per edge.
    - Multiply: shift-add.
    - Divide: restoring, one quotient bit per step.
  - RUN→IDLE on the edge that completes step WIDTH.
    - On that edge: sign-correct the result, write hi/lo, set busy=0, set done=1.
  - done stays high for exactly that one cycle and returns to 0 on the next edge.
- Latency:
  - Start edge at cycle N; hi/lo valid and done=1 after edge N+WIDTH, i.e. 32 cycles later for WIDTH=32.
  - busy is high for exactly WIDTH cycles.
  - A new start may be accepted in the same cycle done=1, since busy=0 then.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - MULT negates the 64-bit product when sign(a)^sign(b)=1.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - DIV rounds toward zero: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
  - Divide by zero (b=0, DIV or DIVU): lo=0xFFFFFFFF, hi=a (original, unmodified). Still takes the full WIDTH cycles, with the normal done pulse.
- Start handling:
  - start while busy=1 is ignored entirely; operands are not re-latched.
  - Operands a/b/op may change freely after the start edge.
- MTHI/MTLO:
  - hi_wen/lo_wen while busy=0 write wdata on that edge; both may assert together.
  - hi_wen/lo_wen while busy=1 are ignored.
  - hi_wen/lo_wen on the completion edge are ignored; the result wins.
  - start together with hi_wen in IDLE: both take effect, and the later result overwrites hi.
- hi/lo hold their values at all other times.
  - They are not disturbed during RUN.
  - MFHI/MFLO during RUN therefore read the previous values; stalling on busy is the control path's job.

Test Plan:
- Reset, then idle for 3 cycles → hi=0, lo=0, busy=0, done=0. Apply MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → busy for 32 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- Attempted corruption during RUN: start a MULTU of 3×5; mid-RUN pulse start with op=DIVU, a=9, b=3, and hi_wen/lo_wen with wdata=0xAAAA5555 → ignored, final hi=0, lo=15, single done pulse. Afterwards, MTLO 0x55 while idle → lo=0x55 on the next cycle.
- Reset mid-operation: assert rst at iteration 10 of a MULTU → next cycle busy=0, hi=lo=0, and no done pulse for the next 40 cycles.
- Back-to-back: assert start (MULTU 2×3) in the done cycle of a previous op → accepted; after 32 more cycles lo=6, and done pulses exactly once per operation.
